// File: rtl/id_ctrl_pkg.sv
// Shared types for the ID/EX control stage: opcodes, ALU/writeback encodings,
// the registered control bundle and the stage state.
package id_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_PASSB  = 5'd10,
    ALU_MUL    = 5'd16,
    ALU_MULH   = 5'd17,
    ALU_MULHSU = 5'd18,
    ALU_MULHU  = 5'd19,
    ALU_DIV    = 5'd20,
    ALU_DIVU   = 5'd21,
    ALU_REM    = 5'd22,
    ALU_REMU   = 5'd23
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_ctrl_e;

  typedef struct packed {
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic        alu_s1;
    logic        alu_s2;
    logic        do_branch;
    logic        do_jump;
    wb_ctrl_e    wb_ctrl;
    alu_op_e     alu_op;
    logic [2:0]  branch_ctrl;
    logic [2:0]  mem_ctrl;
    logic        illegal;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } ctrl_bundle_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

endpackage

// File: rtl/id_ctrl_stage_decode.sv
// Combinational RV32I(+M) decoder: one instruction word into a control bundle
// plus the register-read usage flags needed by the load-use hazard check.
module rv_decode
  import id_ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b0
) (
  input  logic [31:0]  instr,
  output ctrl_bundle_t ctrl,
  output logic         uses_rs1,
  output logic         uses_rs2
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       bad;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  function automatic logic [31:0] imm_i(input logic [31:0] w);
    return {{20{w[31]}}, w[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] w);
    return {{20{w[31]}}, w[31:25], w[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] w);
    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] w);
    return {w[31:12], 12'h000};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] w);
    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
  endfunction

  function automatic alu_op_e base_op(input logic [2:0] fn3, input logic arith);
    case (fn3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return arith ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    ctrl     = '0;
    ctrl.rd  = instr[11:7];
    ctrl.rs1 = instr[19:15];
    ctrl.rs2 = instr[24:20];
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    bad      = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.reg_wr = 1'b1;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
        case (f7)
          F7_BASE: ctrl.alu_op = base_op(f3, 1'b0);
          F7_ALT: begin
            if (f3 == 3'b000)      ctrl.alu_op = ALU_SUB;
            else if (f3 == 3'b101) ctrl.alu_op = ALU_SRA;
            else                   bad = 1'b1;
          end
          F7_MULDIV: begin
            if (ENABLE_M) ctrl.alu_op = alu_op_e'({2'b10, f3});
            else          bad = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end
      OP_I: begin
        ctrl.reg_wr = 1'b1;
        ctrl.alu_s2 = 1'b1;
        ctrl.alu_op = base_op(f3, instr[30]);
        ctrl.imm    = imm_i(instr);
        uses_rs1    = 1'b1;
      end
      OP_LOAD: begin
        ctrl.reg_wr   = 1'b1;
        ctrl.mem_rd   = 1'b1;
        ctrl.alu_s2   = 1'b1;
        ctrl.wb_ctrl  = WB_MEM;
        ctrl.mem_ctrl = f3;
        ctrl.imm      = imm_i(instr);
        uses_rs1      = 1'b1;
        bad           = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OP_STORE: begin
        ctrl.mem_wr   = 1'b1;
        ctrl.alu_s2   = 1'b1;
        ctrl.mem_ctrl = f3;
        ctrl.imm      = imm_s(instr);
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        bad           = (f3 > 3'b010);
      end
      OP_BRANCH: begin
        ctrl.do_branch   = 1'b1;
        ctrl.alu_op      = ALU_SUB;
        ctrl.branch_ctrl = f3;
        ctrl.imm         = imm_b(instr);
        uses_rs1         = 1'b1;
        uses_rs2         = 1'b1;
        bad              = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OP_LUI: begin
        ctrl.reg_wr = 1'b1;
        ctrl.alu_s2 = 1'b1;
        ctrl.alu_op = ALU_PASSB;
        ctrl.imm    = imm_u(instr);
      end
      OP_AUIPC: begin
        ctrl.reg_wr = 1'b1;
        ctrl.alu_s1 = 1'b1;
        ctrl.alu_s2 = 1'b1;
        ctrl.imm    = imm_u(instr);
      end
      OP_JAL: begin
        ctrl.reg_wr  = 1'b1;
        ctrl.do_jump = 1'b1;
        ctrl.alu_s1  = 1'b1;
        ctrl.wb_ctrl = WB_PC4;
        ctrl.imm     = imm_j(instr);
      end
      OP_JALR: begin
        ctrl.reg_wr  = 1'b1;
        ctrl.do_jump = 1'b1;
        ctrl.alu_s2  = 1'b1;
        ctrl.wb_ctrl = WB_PC4;
        ctrl.imm     = imm_i(instr);
        uses_rs1     = 1'b1;
        bad          = (f3 != 3'b000);
      end
      default: bad = 1'b1;
    endcase
    // An illegal word keeps its register fields but carries no side effects.
    if (bad) begin
      ctrl.reg_wr      = 1'b0;
      ctrl.mem_rd      = 1'b0;
      ctrl.mem_wr      = 1'b0;
      ctrl.alu_s1      = 1'b0;
      ctrl.alu_s2      = 1'b0;
      ctrl.do_branch   = 1'b0;
      ctrl.do_jump     = 1'b0;
      ctrl.wb_ctrl     = WB_ALU;
      ctrl.alu_op      = ALU_ADD;
      ctrl.branch_ctrl = 3'b000;
      ctrl.mem_ctrl    = 3'b000;
      ctrl.illegal     = 1'b1;
    end
  end

endmodule

// File: rtl/id_ctrl_stage.sv
// ID/EX pipeline stage: decodes one instruction per cycle into a registered
// control bundle with valid/ready flow control, load-use bubbles and trap halt.
module id_ctrl_stage
  import id_ctrl_pkg::*;
#(
  parameter  int XLEN     = 32,
  parameter  int ENABLE_M = 0,
  parameter  int CNT_W    = 16,
  localparam int ALUOP_W  = (ENABLE_M != 0) ? 5 : 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instr,
  input  logic [XLEN-1:0]    pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [4:0]         rd,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [31:0]        imm,
  output logic               regWR,
  output logic               memRD,
  output logic               memWR,
  output logic               aluS1,
  output logic               aluS2,
  output logic               doBranch,
  output logic               doJump,
  output logic [1:0]         wbCtrl,
  output logic [ALUOP_W-1:0] aluOp,
  output logic [2:0]         branchCtrl,
  output logic [2:0]         memCtrl,
  output logic               illegal,
  output logic [CNT_W-1:0]   bubble_cnt
);

  ctrl_bundle_t     dec_ctrl;
  logic             uses_rs1;
  logic             uses_rs2;
  ctrl_bundle_t     bundle_p1_d, bundle_p1_q;
  logic             vld_p1_d, vld_p1_q;
  logic [XLEN-1:0]  pc_p1_d, pc_p1_q;
  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             advance;
  logic             hazard;
  logic             accept;

  rv_decode #(
    .ENABLE_M (ENABLE_M != 0)
  ) u_decode (
    .instr    (instr),
    .ctrl     (dec_ctrl),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  // Bubble: keep register/immediate fields, drop every control effect.
  function automatic ctrl_bundle_t clear_ctrl(input ctrl_bundle_t b);
    ctrl_bundle_t r;
    r     = '0;
    r.rd  = b.rd;
    r.rs1 = b.rs1;
    r.rs2 = b.rs2;
    r.imm = b.imm;
    return r;
  endfunction

  assign advance = !vld_p1_q || out_ready;

  assign hazard = vld_p1_q && bundle_p1_q.mem_rd && (bundle_p1_q.rd != 5'd0) &&
                  in_valid && advance &&
                  ((uses_rs1 && (instr[19:15] == bundle_p1_q.rd)) ||
                   (uses_rs2 && (instr[24:20] == bundle_p1_q.rd)));

  assign in_ready = advance && (state_q == ST_RUN) && !hazard && !flush;
  assign accept   = in_ready && in_valid;

  always_comb begin
    vld_p1_d    = vld_p1_q;
    bundle_p1_d = bundle_p1_q;
    pc_p1_d     = pc_p1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    if (flush) begin
      vld_p1_d    = 1'b0;
      bundle_p1_d = clear_ctrl(bundle_p1_q);
      state_d     = ST_RUN;
    end else if (advance) begin
      if (accept) begin
        vld_p1_d    = 1'b1;
        bundle_p1_d = dec_ctrl;
        pc_p1_d     = pc;
        if (dec_ctrl.illegal) state_d = ST_HALT;
      end else begin
        vld_p1_d    = 1'b0;
        bundle_p1_d = clear_ctrl(bundle_p1_q);
      end
    end
    if (hazard && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // ---- ID/EX register boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q    <= 1'b0;
      bundle_p1_q <= clear_ctrl(bundle_p1_q);
      state_q     <= ST_RUN;
      cnt_q       <= '0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      bundle_p1_q <= bundle_p1_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    pc_p1_q <= pc_p1_d;
  end

  assign out_valid  = vld_p1_q;
  assign out_pc     = pc_p1_q;
  assign rd         = bundle_p1_q.rd;
  assign rs1        = bundle_p1_q.rs1;
  assign rs2        = bundle_p1_q.rs2;
  assign imm        = bundle_p1_q.imm;
  assign regWR      = bundle_p1_q.reg_wr;
  assign memRD      = bundle_p1_q.mem_rd;
  assign memWR      = bundle_p1_q.mem_wr;
  assign aluS1      = bundle_p1_q.alu_s1;
  assign aluS2      = bundle_p1_q.alu_s2;
  assign doBranch   = bundle_p1_q.do_branch;
  assign doJump     = bundle_p1_q.do_jump;
  assign wbCtrl     = bundle_p1_q.wb_ctrl;
  assign aluOp      = ALUOP_W'(bundle_p1_q.alu_op);
  assign branchCtrl = bundle_p1_q.branch_ctrl;
  assign memCtrl    = bundle_p1_q.mem_ctrl;
  assign illegal    = bundle_p1_q.illegal;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Bench for id_ctrl_stage: directed scenarios then randomized traffic checked
// against a transaction-level reference model of the stage.
module tb_id_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] instr = 32'h0;
  logic [31:0] pc = 32'h0;

  logic        in_ready0, out_valid0, regWR0, memRD0, memWR0, aluS10, aluS20;
  logic        doBranch0, doJump0, illegal0;
  logic [31:0] out_pc0, imm0;
  logic [4:0]  rd0, rs10, rs20;
  logic [1:0]  wbCtrl0;
  logic [3:0]  aluOp0;
  logic [2:0]  branchCtrl0, memCtrl0;
  logic [2:0]  bubble_cnt0;

  logic        in_ready1, out_valid1, regWR1, memRD1, memWR1, aluS11, aluS21;
  logic        doBranch1, doJump1, illegal1;
  logic [31:0] out_pc1, imm1;
  logic [4:0]  rd1, rs11, rs21;
  logic [1:0]  wbCtrl1;
  logic [4:0]  aluOp1;
  logic [2:0]  branchCtrl1, memCtrl1;
  logic [15:0] bubble_cnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ctrl_stage #(.XLEN(32), .ENABLE_M(0), .CNT_W(3)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .instr(instr), .pc(pc), .out_valid(out_valid0), .out_ready(out_ready),
    .out_pc(out_pc0), .rd(rd0), .rs1(rs10), .rs2(rs20), .imm(imm0),
    .regWR(regWR0), .memRD(memRD0), .memWR(memWR0), .aluS1(aluS10), .aluS2(aluS20),
    .doBranch(doBranch0), .doJump(doJump0), .wbCtrl(wbCtrl0), .aluOp(aluOp0),
    .branchCtrl(branchCtrl0), .memCtrl(memCtrl0), .illegal(illegal0),
    .bubble_cnt(bubble_cnt0)
  );

  id_ctrl_stage #(.XLEN(32), .ENABLE_M(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .instr(instr), .pc(pc), .out_valid(out_valid1), .out_ready(out_ready),
    .out_pc(out_pc1), .rd(rd1), .rs1(rs11), .rs2(rs21), .imm(imm1),
    .regWR(regWR1), .memRD(memRD1), .memWR(memWR1), .aluS1(aluS11), .aluS2(aluS21),
    .doBranch(doBranch1), .doJump(doJump1), .wbCtrl(wbCtrl1), .aluOp(aluOp1),
    .branchCtrl(branchCtrl1), .memCtrl(memCtrl1), .illegal(illegal1),
    .bubble_cnt(bubble_cnt1)
  );

  logic [19:0] ctl0;
  assign ctl0 = {regWR0, memRD0, memWR0, aluS10, aluS20, doBranch0, doJump0,
                 wbCtrl0, aluOp0, branchCtrl0, memCtrl0, illegal0};

  // Expected decode of one instruction, derived from the ISA rules.
  typedef struct packed {
    logic rw, mrd, mwr, s1, s2, br, jmp;
    logic [1:0]  wb;
    logic [4:0]  op;
    logic [2:0]  bc, mc;
    logic        ill;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        u1, u2;
  } exp_t;

  function automatic exp_t ref_decode(input logic [31:0] w, input bit m_en);
    exp_t e;
    int op, f3, f7;
    int base_tbl [8];
    base_tbl = '{0, 2, 3, 4, 5, 6, 8, 9};
    e = '0;
    op = int'(w[6:0]); f3 = int'(w[14:12]); f7 = int'(w[31:25]);
    e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
    if (op == 'h33) begin
      e.rw = 1; e.u1 = 1; e.u2 = 1;
      if (f7 == 0) e.op = 5'(base_tbl[f3]);
      else if (f7 == 'h20 && f3 == 0) e.op = 5'd1;
      else if (f7 == 'h20 && f3 == 5) e.op = 5'd7;
      else if (f7 == 1 && m_en) e.op = 5'(16 + f3);
      else e.ill = 1;
    end else if (op == 'h13) begin
      e.rw = 1; e.s2 = 1; e.u1 = 1;
      e.imm = 32'($signed(w[31:20]));
      e.op = (f3 == 5 && w[30]) ? 5'd7 : 5'(base_tbl[f3]);
    end else if (op == 'h03) begin
      e.rw = 1; e.mrd = 1; e.s2 = 1; e.wb = 2'd1; e.u1 = 1; e.mc = 3'(f3);
      e.imm = 32'($signed(w[31:20]));
      e.ill = (f3 == 3 || f3 == 6 || f3 == 7);
    end else if (op == 'h23) begin
      e.mwr = 1; e.s2 = 1; e.u1 = 1; e.u2 = 1; e.mc = 3'(f3);
      e.imm = 32'($signed({w[31:25], w[11:7]}));
      e.ill = (f3 > 2);
    end else if (op == 'h63) begin
      e.br = 1; e.op = 5'd1; e.u1 = 1; e.u2 = 1; e.bc = 3'(f3);
      e.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      e.ill = (f3 == 2 || f3 == 3);
    end else if (op == 'h37) begin
      e.rw = 1; e.s2 = 1; e.op = 5'd10; e.imm = {w[31:12], 12'h0};
    end else if (op == 'h17) begin
      e.rw = 1; e.s1 = 1; e.s2 = 1; e.imm = {w[31:12], 12'h0};
    end else if (op == 'h6F) begin
      e.rw = 1; e.jmp = 1; e.s1 = 1; e.wb = 2'd2;
      e.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
    end else if (op == 'h67) begin
      e.rw = 1; e.jmp = 1; e.s2 = 1; e.wb = 2'd2; e.u1 = 1;
      e.imm = 32'($signed(w[31:20]));
      e.ill = (f3 != 0);
    end else begin
      e.ill = 1;
    end
    if (e.ill) begin
      {e.rw, e.mrd, e.mwr, e.s1, e.s2, e.br, e.jmp} = '0;
      e.wb = '0; e.op = '0; e.bc = '0; e.mc = '0;
    end
    return e;
  endfunction

  function automatic logic [19:0] ctl_of(input exp_t e);
    return {e.rw, e.mrd, e.mwr, e.s1, e.s2, e.br, e.jmp, e.wb, e.op[3:0], e.bc, e.mc, e.ill};
  endfunction

  // Reference model state for dut0 (ENABLE_M=0, 3-bit counter).
  bit          m_vld = 0;
  bit          m_halt = 0;
  int          m_cnt = 0;
  exp_t        m_b;
  logic [31:0] m_pc;

  function automatic bit m_hazard();
    exp_t d;
    d = ref_decode(instr, 1'b0);
    return m_vld && m_b.mrd && (m_b.rd != 0) && in_valid && (!m_vld || out_ready) &&
           ((d.u1 && instr[19:15] == m_b.rd) || (d.u2 && instr[24:20] == m_b.rd));
  endfunction

  function automatic bit model_in_ready();
    return (!m_vld || out_ready) && !m_halt && !m_hazard() && !flush;
  endfunction

  always @(posedge clk) begin : model
    exp_t d;
    bit   hz, acc, adv;
    if (rst) begin
      m_vld = 0; m_halt = 0; m_cnt = 0;
    end else begin
      d   = ref_decode(instr, 1'b0);
      hz  = m_hazard();
      acc = model_in_ready() && in_valid;
      adv = !m_vld || out_ready;
      if (hz && m_cnt < 7) m_cnt = m_cnt + 1;
      if (flush) begin
        m_vld = 0; m_halt = 0;
      end else if (adv) begin
        if (acc) begin
          m_vld = 1; m_b = d; m_pc = pc;
          if (d.ill) m_halt = 1;
        end else begin
          m_vld = 0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".vld"}, 32'(out_valid0), 32'(m_vld));
    chk({tag, ".ctl"}, 32'(ctl0), m_vld ? 32'(ctl_of(m_b)) : 32'd0);
    chk({tag, ".cnt"}, 32'(bubble_cnt0), 32'(m_cnt));
    if (m_vld) begin
      chk({tag, ".regs"}, 32'({rd0, rs10, rs20}), 32'({m_b.rd, m_b.rs1, m_b.rs2}));
      chk({tag, ".imm"}, imm0, m_b.imm);
      chk({tag, ".pc"}, out_pc0, m_pc);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] p,
                       input logic f, input logic ordy);
    in_valid = v; instr = w; pc = p; flush = f; out_ready = ordy;
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] rdx, r1, r2;
    logic [2:0] f3;
    logic [6:0] f7, op;
    rdx = 5'($urandom_range(0, 3)); r1 = 5'($urandom_range(0, 3)); r2 = 5'($urandom_range(0, 3));
    f3 = 3'($urandom_range(0, 7)); f7 = 7'($urandom);
    case ($urandom_range(0, 19))
      0, 1, 2, 3: begin
        op = 7'h33;
        case ($urandom_range(0, 4))
          0, 1:    f7 = 7'h00;
          2:       f7 = 7'h20;
          3:       f7 = 7'h01;
          default: f7 = 7'($urandom);
        endcase
      end
      4, 5:          op = 7'h13;
      6, 7, 8, 9:    op = 7'h03;
      10, 11:        op = 7'h23;
      12, 13:        op = 7'h63;
      14:            op = 7'h37;
      15:            op = 7'h17;
      16:            op = 7'h6F;
      17: begin
        op = 7'h67;
        if ($urandom_range(0, 3) != 0) f3 = 3'd0;
      end
      default: return $urandom;
    endcase
    return {f7, r2, r1, f3, rdx, op};
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.out_valid", 32'(out_valid0), 32'd0);
    chk("rst.ctl", 32'(ctl0), 32'd0);
    chk("rst.bubble_cnt", 32'(bubble_cnt0), 32'd0);
    chk("rst.in_ready", 32'(in_ready0), 32'd1);
    check_all("rst");

    // add x1,x2,x3
    drive(1, 32'h003100B3, 32'h100, 0, 1);
    chk("add.in_ready", 32'(in_ready0), 32'd1);
    @(negedge clk);
    chk("add.out_valid", 32'(out_valid0), 32'd1);
    chk("add.regWR", 32'(regWR0), 32'd1);
    chk("add.aluOp", 32'(aluOp0), 32'd0);
    chk("add.regs", 32'({rd0, rs10, rs20}), 32'({5'd1, 5'd2, 5'd3}));
    chk("add.wbCtrl", 32'(wbCtrl0), 32'd0);
    chk("add.pc", out_pc0, 32'h100);
    check_all("add");

    // lw x5,0(x1) then dependent add x6,x5,x5
    drive(1, 32'h0000A283, 32'h104, 0, 1);
    @(negedge clk);
    chk("lw.memRD", 32'({memRD0, wbCtrl0, rd0}), 32'({1'b1, 2'b01, 5'd5}));
    check_all("lw");
    drive(1, 32'h00528333, 32'h108, 0, 1);
    chk("hz.in_ready", 32'(in_ready0), 32'd0);
    @(negedge clk);
    chk("hz.out_valid", 32'(out_valid0), 32'd0);
    chk("hz.bubble_cnt", 32'(bubble_cnt0), 32'd1);
    chk("hz.in_ready_after", 32'(in_ready0), 32'd1);
    check_all("hz");
    @(negedge clk);
    chk("hz.issued", 32'({out_valid0, rd0, rs10, regWR0}), 32'({1'b1, 5'd6, 5'd5, 1'b1}));
    check_all("hz2");

    // stall: hold add x6 for 3 cycles with a sub pending
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h40208133, 32'h10C, 0, 0);
      chk("stall.in_ready", 32'(in_ready0), 32'd0);
      @(negedge clk);
      chk("stall.held", 32'({out_valid0, rd0, regWR0}), 32'({1'b1, 5'd6, 1'b1}));
      check_all("stall");
    end
    drive(1, 32'h40208133, 32'h10C, 0, 1);
    chk("release.in_ready", 32'(in_ready0), 32'd1);
    @(negedge clk);
    chk("release.sub", 32'({out_valid0, rd0, aluOp0}), 32'({1'b1, 5'd2, 4'd1}));
    check_all("release");

    // mul: legal only with the M extension
    drive(1, 32'h023100B3, 32'h110, 0, 1);
    @(negedge clk);
    chk("mulM.aluOp", 32'(aluOp1), 32'd16);
    chk("mulM.flags", 32'({out_valid1, illegal1, regWR1, wbCtrl1}), 32'({1'b1, 1'b0, 1'b1, 2'b00}));
    chk("mulM.regs", 32'({rd1, rs11, rs21}), 32'({5'd1, 5'd2, 5'd3}));
    chk("mul.illegal", 32'({out_valid0, illegal0, regWR0}), 32'({1'b1, 1'b1, 1'b0}));
    check_all("mul");
    drive(1, 32'h003100B3, 32'h114, 0, 1);
    chk("halt.in_ready", 32'(in_ready0), 32'd0);
    chk("mulM.in_ready", 32'(in_ready1), 32'd1);
    @(negedge clk);
    chk("halt.in_ready2", 32'(in_ready0), 32'd0);
    chk("halt.drained", 32'(out_valid0), 32'd0);
    check_all("halt");
    drive(1, 32'h003100B3, 32'h114, 1, 1);
    chk("flush.in_ready", 32'(in_ready0), 32'd0);
    @(negedge clk);
    drive(0, 32'h0, 32'h0, 0, 1);
    chk("flush.out_valid", 32'(out_valid0), 32'd0);
    chk("flush.in_ready_run", 32'(in_ready0), 32'd1);
    check_all("flush");

    // unknown opcode, then flush with a held bundle and a new instruction
    drive(1, 32'h0000001F, 32'h120, 0, 1);
    @(negedge clk);
    chk("op1f.illegal", 32'({out_valid0, illegal0}), 32'({1'b1, 1'b1}));
    check_all("op1f");
    drive(1, 32'h000100E7, 32'h124, 1, 0);
    chk("flushboth.in_ready", 32'(in_ready0), 32'd0);
    @(negedge clk);
    chk("flushboth.out", 32'({out_valid0, illegal0}), 32'd0);
    check_all("flushboth");
    drive(1, 32'h000100E7, 32'h124, 0, 1);
    chk("jalr.in_ready", 32'(in_ready0), 32'd1);
    @(negedge clk);
    chk("jalr.ctl", 32'({out_valid0, doJump0, wbCtrl0, aluS20, rd0, illegal0}),
        32'({1'b1, 1'b1, 2'b10, 1'b1, 5'd1, 1'b0}));
    check_all("jalr");

    // drive the bubble counter into saturation and beyond
    for (int k = 0; k < 7; k++) begin
      drive(1, 32'h0000A283, 32'h200, 0, 1);
      @(negedge clk);
      check_all("sat.lw");
      drive(1, 32'h00528333, 32'h204, 0, 1);
      @(negedge clk);
      check_all("sat.bub");
      @(negedge clk);
      check_all("sat.add");
      if (k == 5) chk("sat.full", 32'(bubble_cnt0), 32'd7);
    end
    chk("sat.hold", 32'(bubble_cnt0), 32'd7);

    // randomized traffic against the reference model
    drive(0, 32'h0, 32'h0, 0, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      check_all("rnd");
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) < 7);
      chk("rnd.in_ready", 32'(in_ready0), 32'(model_in_ready()));
      @(negedge clk);
    end
    check_all("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
